regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 101 ++++++++++
 tb/tb_regfile_mp.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with an issue scoreboard.
// x0 is hardwired to zero. Each register carries a pending bit that is set
// when an instruction targeting it issues and cleared when its result is
// written back; busy_count tracks how many registers are pending.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data to matching read ports (default build reads registered state only).
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = AW + 1
) (
    input  logic                    aclk,
    input  logic                    resetn,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*XLEN-1:0]   rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic [NWRITE-1:0]       wr_en,
    input  logic [NWRITE*AW-1:0]    wr_addr,
    input  logic [NWRITE*XLEN-1:0]  wr_data,
    input  logic                    iss_valid,
    input  logic [AW-1:0]           iss_addr,
    output logic                    iss_ready,
    output logic [CW-1:0]           busy_count
);

    logic [XLEN-1:0] regs      [NREGS];
    logic [XLEN-1:0] data_next [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pend_next;
    logic [CW-1:0]    count_next;
    logic             iss_fire;

    // An issue is refused while its destination is still pending (no WAW); x0 never blocks
    always_comb begin
        iss_ready = (iss_addr == '0) || !pending[iss_addr];
        iss_fire  = iss_valid && iss_ready && (iss_addr != '0);
    end

    // Next register/scoreboard state: later write ports overwrite earlier ones, issue beats writeback
    always_comb begin
        data_next = regs;
        pend_next = pending;
        for (int w = 0; w < NWRITE; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
                data_next[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
                pend_next[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (iss_fire) begin
            pend_next[iss_addr] = 1'b1;
        end
        data_next[0] = '0;
        pend_next[0] = 1'b0;
    end

    // Population count of the next pending vector so busy_count moves on the same edge as the bits
    always_comb begin
        count_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            count_next = count_next + CW'(pend_next[i]);
        end
    end

    // State registers with synchronous active-low reset that overrides writes and issues
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pending    <= '0;
            busy_count <= '0;
        end else begin
            regs       <= data_next;
            pending    <= pend_next;
            busy_count <= count_next;
        end
    end

    // Combinational read ports, optionally bypassing the winning same-cycle write
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NREAD; p++) begin
            rd_data[p*XLEN +: XLEN] = regs[rd_addr[p*AW +: AW]];
            rd_busy[p]              = pending[rd_addr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NWRITE; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] != '0) &&
                    (wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW])) begin
                    rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                    rd_busy[p]              = iss_fire && (iss_addr == rd_addr[p*AW +: AW]);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp built with
// two read and two write ports, default (no bypass) configuration.
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int AW     = 5;

    logic                   aclk;
    logic                   resetn;
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD*XLEN-1:0]  rd_data;
    logic [NREAD-1:0]       rd_busy;
    logic [NWRITE-1:0]      wr_en;
    logic [NWRITE*AW-1:0]   wr_addr;
    logic [NWRITE*XLEN-1:0] wr_data;
    logic                   iss_valid;
    logic [AW-1:0]          iss_addr;
    logic                   iss_ready;
    logic [AW:0]            busy_count;

    int vectors;
    int miscompares;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)
    ) dut (
        .aclk(aclk), .resetn(resetn),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .busy_count(busy_count)
    );

    // Free-running clock
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        rd_addr = {5'd9, 5'd5};
        idle();
        iss_addr = 5'd3;
        tick();
        tick();
        vectors++;
        if (rd_data !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_rd_data: got %h expected %h", rd_data, 64'h0);
        end
        vectors++;
        if (rd_busy !== 2'b00 || busy_count !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_busy: got busy=%b count=%0d expected busy=00 count=0", rd_busy, busy_count);
        end
        vectors++;
        if (iss_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_iss_ready: got %b expected 1", iss_ready);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd5};
        wr_data = {32'h0, 32'hDEADBEEF};
        rd_addr = {5'd5, 5'd5};
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL same_cycle_read: got %h expected %h", rd_data[31:0], 32'h0);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (rd_data !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            miscompares++;
            $display("[TB] FAIL write_read: got %h expected %h", rd_data, {32'hDEADBEEF, 32'hDEADBEEF});
        end
    endtask

    task automatic test_x0();
        wr_en     = 2'b01;
        wr_addr   = {5'd0, 5'd0};
        wr_data   = {32'h0, 32'h1234};
        iss_valid = 1'b1;
        iss_addr  = 5'd0;
        rd_addr   = {5'd0, 5'd0};
        #1;
        vectors++;
        if (iss_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL x0_ready_pre: got %b expected 1", iss_ready);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL x0_read: got data=%h busy=%b expected data=0 busy=0", rd_data[31:0], rd_busy[0]);
        end
        vectors++;
        if (busy_count !== 6'd0 || iss_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL x0_scoreboard: got count=%0d ready=%b expected count=0 ready=1", busy_count, iss_ready);
        end
    endtask

    task automatic test_dual_write();
        wr_en   = 2'b11;
        wr_addr = {5'd7, 5'd7};
        wr_data = {32'h22, 32'h11};
        tick();
        wr_addr = {5'd9, 5'd8};
        wr_data = {32'hBB, 32'hAA};
        tick();
        idle();
        rd_addr = {5'd8, 5'd7};
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'h22) begin
            miscompares++;
            $display("[TB] FAIL dual_write_same_index: got %h expected %h", rd_data[31:0], 32'h22);
        end
        vectors++;
        if (rd_data[63:32] !== 32'hAA) begin
            miscompares++;
            $display("[TB] FAIL dual_write_port0: got %h expected %h", rd_data[63:32], 32'hAA);
        end
        rd_addr = {5'd9, 5'd9};
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'hBB) begin
            miscompares++;
            $display("[TB] FAIL dual_write_port1: got %h expected %h", rd_data[31:0], 32'hBB);
        end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1;
        iss_addr  = 5'd3;
        rd_addr   = {5'd3, 5'd3};
        tick();
        #1;
        vectors++;
        if (rd_busy !== 2'b11 || busy_count !== 6'd1 || iss_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL issue_mark: got busy=%b count=%0d ready=%b expected busy=11 count=1 ready=0", rd_busy, busy_count, iss_ready);
        end
        tick();
        vectors++;
        if (busy_count !== 6'd1) begin
            miscompares++;
            $display("[TB] FAIL issue_blocked: got count=%0d expected 1", busy_count);
        end
        idle();
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd3};
        wr_data = {32'h0, 32'h333};
        tick();
        idle();
        iss_addr = 5'd3;
        #1;
        vectors++;
        if (rd_busy !== 2'b00 || busy_count !== 6'd0 || iss_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL writeback_clear: got busy=%b count=%0d ready=%b expected busy=00 count=0 ready=1", rd_busy, busy_count, iss_ready);
        end
        vectors++;
        if (rd_data[31:0] !== 32'h333) begin
            miscompares++;
            $display("[TB] FAIL writeback_data: got %h expected %h", rd_data[31:0], 32'h333);
        end
    endtask

    task automatic test_issue_write_same();
        iss_valid = 1'b1;
        iss_addr  = 5'd4;
        tick();
        wr_en     = 2'b01;
        wr_addr   = {5'd0, 5'd3};
        wr_data   = {32'h0, 32'h444};
        iss_addr  = 5'd3;
        tick();
        idle();
        rd_addr = {5'd4, 5'd3};
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'h444 || rd_busy !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL issue_wins: got data=%h busy=%b expected data=444 busy=11", rd_data[31:0], rd_busy);
        end
        vectors++;
        if (busy_count !== 6'd2) begin
            miscompares++;
            $display("[TB] FAIL issue_wins_count: got %0d expected 2", busy_count);
        end
        wr_en   = 2'b11;
        wr_addr = {5'd4, 5'd3};
        wr_data = {32'h4, 32'h3};
        tick();
        idle();
        #1;
        vectors++;
        if (busy_count !== 6'd0 || rd_busy !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL double_clear: got count=%0d busy=%b expected count=0 busy=00", busy_count, rd_busy);
        end
    endtask

    task automatic test_reset_override();
        for (int i = 1; i < NREGS; i++) begin
            iss_valid = 1'b1;
            iss_addr  = AW'(i);
            tick();
        end
        idle();
        #1;
        vectors++;
        if (busy_count !== 6'd31) begin
            miscompares++;
            $display("[TB] FAIL all_pending_count: got %0d expected 31", busy_count);
        end
        resetn    = 1'b0;
        wr_en     = 2'b01;
        wr_addr   = {5'd0, 5'd10};
        wr_data   = {32'h0, 32'h55};
        iss_valid = 1'b1;
        iss_addr  = 5'd2;
        tick();
        idle();
        resetn   = 1'b1;
        iss_addr = 5'd2;
        #1;
        vectors++;
        if (busy_count !== 6'd0 || iss_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_override_sb: got count=%0d ready=%b expected count=0 ready=1", busy_count, iss_ready);
        end
        for (int i = 0; i < NREGS; i++) begin
            rd_addr = {AW'(i), AW'(i)};
            #1;
            vectors++;
            if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL reset_override_x%0d: got data=%h busy=%b expected data=0 busy=00", i, rd_data, rd_busy);
            end
        end
    endtask

    // Run all scenarios in order and report
    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        rd_addr     = '0;
        idle();
        test_reset();
        test_write_read();
        test_x0();
        test_dual_write();
        test_scoreboard();
        test_issue_write_same();
        test_reset_override();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
